// File: rtl/mem_arbiter.sv
// Merges instruction-fetch and data-access requests onto one single-port memory channel.
// One transaction in flight; data wins by default, with a bounded streak so fetch cannot starve.
module mem_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DMEM_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_wen,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_mask,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_wen,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_mask,
  input  logic                m_resp_valid,
  input  logic [DATA_W-1:0]   m_resp_data,
  output logic                err_unexpected_resp
);

  localparam int unsigned MaskW     = DATA_W / 8;
  localparam logic [3:0]  MaxStreak = 4'(MAX_DMEM_STREAK);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_is_d_q, owner_is_d_d;
  logic [3:0]          streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MaskW-1:0]    mask_q, mask_d;
  logic                i_resp_valid_q, i_resp_valid_d;
  logic                d_resp_valid_q, d_resp_valid_d;
  logic [DATA_W-1:0]   i_resp_data_q, i_resp_data_d;
  logic [DATA_W-1:0]   d_resp_data_q, d_resp_data_d;
  logic                err_q, err_d;
  logic                grant_i, grant_d;

  // Fetch is forced through once the data side has used up its streak.
  assign grant_d = d_req_valid & ~(i_req_valid & (streak_q == MaxStreak));
  assign grant_i = i_req_valid & ~grant_d;

  always_comb begin
    state_d        = state_q;
    owner_is_d_d   = owner_is_d_q;
    streak_d       = streak_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    mask_d         = mask_q;
    i_resp_valid_d = 1'b0;
    d_resp_valid_d = 1'b0;
    i_resp_data_d  = i_resp_data_q;
    d_resp_data_d  = d_resp_data_q;
    err_d          = err_q | (m_resp_valid & (state_q != StResp));

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d      = StReq;
          owner_is_d_d = 1'b1;
          addr_d       = d_req_addr;
          wen_d        = d_req_wen;
          wdata_d      = d_req_wdata;
          mask_d       = d_req_mask;
          if (!i_req_valid) begin
            streak_d = 4'd0;
          end else if (streak_q != MaxStreak) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (grant_i) begin
          state_d      = StReq;
          owner_is_d_d = 1'b0;
          addr_d       = i_req_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          mask_d       = '1;
          streak_d     = 4'd0;
        end
      end
      StReq: begin
        if (m_req_ready) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (m_resp_valid) begin
          state_d = StIdle;
          if (owner_is_d_q) begin
            d_resp_valid_d = 1'b1;
            d_resp_data_d  = m_resp_data;
          end else begin
            i_resp_valid_d = 1'b1;
            i_resp_data_d  = m_resp_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      owner_is_d_q   <= 1'b0;
      streak_q       <= 4'd0;
      addr_q         <= '0;
      wen_q          <= 1'b0;
      wdata_q        <= '0;
      mask_q         <= '0;
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
      d_resp_data_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_is_d_q   <= owner_is_d_d;
      streak_q       <= streak_d;
      addr_q         <= addr_d;
      wen_q          <= wen_d;
      wdata_q        <= wdata_d;
      mask_q         <= mask_d;
      i_resp_valid_q <= i_resp_valid_d;
      d_resp_valid_q <= d_resp_valid_d;
      i_resp_data_q  <= i_resp_data_d;
      d_resp_data_q  <= d_resp_data_d;
      err_q          <= err_d;
    end
  end

  assign i_req_ready         = (state_q == StIdle) & grant_i;
  assign d_req_ready         = (state_q == StIdle) & grant_d;
  assign m_req_valid         = (state_q == StReq);
  assign m_req_addr          = addr_q;
  assign m_req_wen           = wen_q;
  assign m_req_wdata         = wdata_q;
  assign m_req_mask          = mask_q;
  assign i_resp_valid        = i_resp_valid_q;
  assign i_resp_data         = i_resp_data_q;
  assign d_resp_valid        = d_resp_valid_q;
  assign d_resp_data         = d_resp_data_q;
  assign err_unexpected_resp = err_q;

endmodule
